// File: rtl/key_sched_inv.sv
// Sequential AES-128 key schedule walker: loads the round-10 key and streams round keys 10..0.
// Define KEY_SCHED_INV_FWD_EN to add a dir input that also allows forward expansion (rounds 0..10).
//
// state  | meaning
// IDLE   | ready for start, no beat presented
// EMIT   | rk_out/rk_round presented, advancing one round per accepted beat
// DONE   | one-cycle done pulse after the final beat; start not yet accepted
module key_sched_inv #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key_in,
`ifdef KEY_SCHED_INV_FWD_EN
    input  logic         dir,
`endif
    output logic         ready,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_round,
    output logic         done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EMIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [3:0] LAST   = 4'(NR);

    // Forward AES S-box; entry 0 sits in the top byte, so lookups index with ~x.
    localparam logic [255:0][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[~x];
    endfunction

    function automatic logic [31:0] sub_rot(input logic [31:0] w);
        return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    logic [1:0]   state;
    logic         fwd;
    logic         at_last;
    logic [3:0]   start_round;
    logic [127:0] rk_next;
    logic [31:0]  a0, a1, a2, a3;
    logic [31:0]  p0, p1, p2, p3;

    assign {a0, a1, a2, a3} = rk_out;

    // Undo one expansion step: later words recover earlier ones by pairwise XOR.
    assign p3 = a3 ^ a2;
    assign p2 = a2 ^ a1;
    assign p1 = a1 ^ a0;
    assign p0 = a0 ^ sub_rot(p3) ^ {rcon(rk_round), 24'h0};

`ifdef KEY_SCHED_INV_FWD_EN
    logic        dir_q;
    logic [31:0] n0, n1, n2, n3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            dir_q <= 1'b0;
        else if (state == S_IDLE && start)
            dir_q <= dir;
    end

    assign fwd         = dir_q;
    assign start_round = dir ? 4'd0 : LAST;
    assign n0          = a0 ^ sub_rot(a3) ^ {rcon(rk_round + 4'd1), 24'h0};
    assign n1          = a1 ^ n0;
    assign n2          = a2 ^ n1;
    assign n3          = a3 ^ n2;
    assign rk_next     = fwd ? {n0, n1, n2, n3} : {p0, p1, p2, p3};
`else
    assign fwd         = 1'b0;
    assign start_round = LAST;
    assign rk_next     = {p0, p1, p2, p3};
`endif

    assign at_last  = fwd ? (rk_round == LAST) : (rk_round == 4'd0);
    assign ready    = (state == S_IDLE);
    assign rk_valid = (state == S_EMIT);
    assign done     = (state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            rk_out   <= '0;
            rk_round <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        rk_out   <= key_in;
                        rk_round <= start_round;
                        state    <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (rk_ready) begin
                        if (at_last) begin
                            state <= S_DONE;
                        end else begin
                            rk_out   <= rk_next;
                            rk_round <= fwd ? rk_round + 4'd1 : rk_round - 4'd1;
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_key_sched_inv.sv
// Directed bench for key_sched_inv: known AES-128 schedules, backpressure, busy start, async reset.
module tb_key_sched_inv;

    typedef struct {
        logic [3:0]   rnd;
        logic [127:0] key;
    } vec_t;

    localparam logic [255:0][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [127:0] K0    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K10   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] CK2   = 128'h0f1571c947d9e8590cb7add6af7f6798;
    localparam logic [127:0] CK2_10 = 128'hb48ef352ba98134e7f4d592086261876;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [127:0] key_in = '0;
    logic         rk_ready = 1'b0;
`ifdef KEY_SCHED_INV_FWD_EN
    logic         dir = 1'b0;
`endif
    logic         ready, rk_valid, done;
    logic [127:0] rk_out;
    logic [3:0]   rk_round;

    int errors = 0;
    int checks = 0;
    int nb, cyc;
    vec_t         vt[11];
    logic [127:0] exp_rk[11];
    logic [127:0] got_out[11];
    logic [3:0]   got_rnd[11];

    always #5 clk = ~clk;

    key_sched_inv dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .key_in   (key_in),
`ifdef KEY_SCHED_INV_FWD_EN
        .dir      (dir),
`endif
        .ready    (ready),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .rk_out   (rk_out),
        .rk_round (rk_round),
        .done     (done)
    );

    function automatic logic [7:0] tb_sbox(input logic [7:0] x);
        return SBOX[~x];
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference forward expansion (kExtend) with Rcon generated by GF(2^8) doubling.
    task automatic model_expand(input logic [127:0] ck);
        logic [31:0] w[44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = ck[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {tb_sbox(t[23:16]), tb_sbox(t[15:8]), tb_sbox(t[7:0]), tb_sbox(t[31:24])} ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic do_start(input logic [127:0] k);
        start  = 1'b1;
        key_in = k;
        @(negedge clk);
        start  = 1'b0;
    endtask

    // Consume beats at negedges; optional random backpressure and one stray start at beat poke_at.
    task automatic collect(input bit bp, input int nstop, input int poke_at);
        logic [127:0] h_out;
        logic [3:0]   h_rnd;
        bit stalled, poked;
        h_out = '0; h_rnd = '0; stalled = 1'b0; poked = 1'b0;
        nb = 0; cyc = 0;
        for (int i = 0; i < 11; i++) begin
            got_out[i] = '0;
            got_rnd[i] = '0;
        end
        while (nb < nstop && cyc < 400) begin
            if (stalled) begin
                chk("stall_valid", 128'(rk_valid), 128'd1);
                chk("stall_out", rk_out, h_out);
                chk("stall_round", 128'(rk_round), 128'(h_rnd));
            end
            start = 1'b0;
            if (nb == poke_at && !poked) begin
                start  = 1'b1;
                key_in = CK2_10;
                poked  = 1'b1;
            end
            rk_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rk_valid && rk_ready) begin
                got_out[nb] = rk_out;
                got_rnd[nb] = rk_round;
                nb++;
                stalled = 1'b0;
            end else begin
                stalled = rk_valid;
                h_out   = rk_out;
                h_rnd   = rk_round;
            end
            @(negedge clk);
            cyc++;
        end
        rk_ready = 1'b0;
        start    = 1'b0;
        chk("beat_count", 128'(nb), 128'(nstop));
    endtask

    task automatic cmp_table(input string tag);
        for (int i = 0; i < 11; i++) begin
            chk({tag, "_round"}, 128'(got_rnd[i]), 128'(vt[i].rnd));
            chk({tag, "_key"}, got_out[i], vt[i].key);
        end
    endtask

    task automatic cmp_model(input string tag, input bit fwd);
        for (int i = 0; i < 11; i++) begin
            int r;
            r = fwd ? i : 10 - i;
            chk({tag, "_round"}, 128'(got_rnd[i]), 128'(r));
            chk({tag, "_key"}, got_out[i], exp_rk[r]);
        end
    endtask

    // Called at the negedge after the final handshake; a start here must be ignored.
    task automatic finish_chk(input string tag);
        chk({tag, "_done_hi"}, 128'(done), 128'd1);
        chk({tag, "_ready_lo"}, 128'(ready), 128'd0);
        chk({tag, "_valid_lo"}, 128'(rk_valid), 128'd0);
        start  = 1'b1;
        key_in = CK2_10;
        @(negedge clk);
        start  = 1'b0;
        chk({tag, "_done_lo"}, 128'(done), 128'd0);
        chk({tag, "_ready_hi"}, 128'(ready), 128'd1);
        chk({tag, "_valid_idle"}, 128'(rk_valid), 128'd0);
    endtask

    initial begin
        vt[0]  = '{4'd10, K10};
        vt[1]  = '{4'd9,  128'hac7766f319fadc2128d12941575c006e};
        vt[2]  = '{4'd8,  128'head27321b58dbad2312bf5607f8d292f};
        vt[3]  = '{4'd7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f};
        vt[4]  = '{4'd6,  128'h6d88a37a110b3efddbf98641ca0093fd};
        vt[5]  = '{4'd5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc};
        vt[6]  = '{4'd4,  128'hef44a541a8525b7fb671253bdb0bad00};
        vt[7]  = '{4'd3,  128'h3d80477d4716fe3e1e237e446d7a883b};
        vt[8]  = '{4'd2,  128'hf2c295f27a96b9435935807a7359f67f};
        vt[9]  = '{4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
        vt[10] = '{4'd0,  K0};

        #3;
        chk("rst_ready", 128'(ready), 128'd1);
        chk("rst_valid", 128'(rk_valid), 128'd0);
        chk("rst_out", rk_out, 128'd0);
        chk("rst_round", 128'(rk_round), 128'd0);
        chk("rst_done", 128'(done), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_start(K10);
        collect(1'b0, 11, -1);
        chk("latency_cycles", 128'(cyc), 128'd11);
        cmp_table("basic");
        finish_chk("basic");

        do_start(K10);
        collect(1'b1, 11, -1);
        cmp_table("bp");
        finish_chk("bp");

        model_expand(CK2);
        do_start(CK2_10);
        collect(1'b0, 11, -1);
        cmp_model("key2", 1'b0);
        chk("key2_round0", got_out[10], CK2);
        finish_chk("key2");

        do_start(K10);
        collect(1'b0, 11, 4);
        cmp_table("busy");
        finish_chk("busy");

        do_start(K10);
        collect(1'b0, 6, -1);
        chk("pre_rst_round", 128'(rk_round), 128'd4);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 128'(rk_valid), 128'd0);
        chk("arst_ready", 128'(ready), 128'd1);
        chk("arst_out", rk_out, 128'd0);
        chk("arst_round", 128'(rk_round), 128'd0);
        repeat (2) @(negedge clk);
        chk("arst_hold_valid", 128'(rk_valid), 128'd0);
        rst_n = 1'b1;
        @(negedge clk);
        do_start(K10);
        collect(1'b0, 11, -1);
        cmp_table("replay");
        finish_chk("replay");

`ifdef KEY_SCHED_INV_FWD_EN
        model_expand(K0);
        dir = 1'b1;
        do_start(K0);
        dir = 1'b0;
        collect(1'b0, 11, -1);
        cmp_model("fwd", 1'b1);
        chk("fwd_round1", got_out[1], 128'ha0fafe1788542cb123a339392a6c7605);
        chk("fwd_round10", got_out[10], K10);
        finish_chk("fwd");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
